// File: rtl/cfg_lut_fabric.sv
// Bit-sliced LUT fabric: each slice has a 3-input sum LUT and carry LUT in a ripple chain.
// Config is streamed into a shadow store and committed atomically; FABRIC_CFG_BCAST_EN loads one slice image for all slices.
module cfg_lut_fabric #(
  parameter int WIDTH = 8,
  parameter int CFG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_loaded,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] In_1,
  input  logic [WIDTH-1:0] In_2,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  localparam int CFG_BITS = WIDTH * 16;
`ifdef FABRIC_CFG_BCAST_EN
  localparam int SHADOW_W = 16;
`else
  localparam int SHADOW_W = CFG_BITS;
`endif
  localparam int NBEATS = SHADOW_W / CFG_W;
  localparam int REPL   = CFG_BITS / SHADOW_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {UNCFG, LOAD, RUN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic                commit;
  logic                loaded_q, done_q, out_valid_q, cout_q;
  logic [WIDTH-1:0]    sum_q;
  logic [WIDTH-1:0]    sum_c;
  logic                cout_c;

  // A start pulse during LOAD outranks a coincident beat, so the final beat is dropped without commit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    commit   = 1'b0;
    case (state_q)
      LOAD: begin
        if (cfg_start) begin
          cnt_d = '0;
        end else if (cfg_valid) begin
          shadow_d[int'(cnt_q) * CFG_W +: CFG_W] = cfg_data;
          if (cnt_q == CNT_W'(NBEATS - 1)) begin
            commit  = 1'b1;
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
    endcase
    if (commit) begin
      active_d = {REPL{shadow_d}};
    end
  end

  // Ripple through the active configuration; index is {carry_in, In_2, In_1}.
  always_comb begin
    logic       c;
    logic [2:0] idx;
    c     = cin;
    sum_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx      = {c, In_2[i], In_1[i]};
      sum_c[i] = active_q[16 * i + int'(idx)];
      c        = active_q[16 * i + 8 + int'(idx)];
    end
    cout_c = c;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= UNCFG;
      cnt_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      loaded_q    <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      done_q   <= commit;
      if (commit) begin
        loaded_q <= 1'b1;
      end
      // Uses pre-edge active_q, so an operation on the commit edge sees the old config.
      if (in_valid && loaded_q) begin
        out_valid_q <= 1'b1;
        sum_q       <= sum_c;
        cout_q      <= cout_c;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign cfg_ready  = (state_q == LOAD);
  assign cfg_done   = done_q;
  assign cfg_loaded = loaded_q;
  assign out_valid  = out_valid_q;
  assign Sum        = sum_q;
  assign Cout       = cout_q;
endmodule

// File: tb/tb_cfg_lut_fabric.sv
// Directed self-checking bench for cfg_lut_fabric (adder / XOR configs, reload, abort, mid-load reset).
module tb_cfg_lut_fabric;
`ifdef FABRIC_CFG_BCAST_EN
  localparam int NB = 2;
`else
  localparam int NB = 16;
`endif
  localparam int MID = (NB > 2) ? 5 : 1;
  localparam int RB  = (NB > 8) ? 7 : 1;

  logic       clk = 1'b0;
  logic       reset, cfg_start, cfg_valid, cfg_ready, cfg_done, cfg_loaded;
  logic [7:0] cfg_data;
  logic       in_valid, cin, out_valid, Cout;
  logic [7:0] In_1, In_2, Sum;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  cfg_lut_fabric #(.WIDTH(8), .CFG_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
    .cfg_loaded(cfg_loaded), .in_valid(in_valid), .In_1(In_1), .In_2(In_2),
    .cin(cin), .out_valid(out_valid), .Sum(Sum), .Cout(Cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (cfg_done === 1'b1) done_cnt++;
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic beats(input logic [7:0] b0, input logic [7:0] b1, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = (k % 2 == 0) ? b0 : b1;
      step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic c);
    in_valid = 1'b1; In_1 = a; In_2 = b; cin = c;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; In_1 = 8'h12; In_2 = 8'h34; cin = 1'b0;
    step();
    reset = 1'b1;
    step(); step();
    vectors++;
    if (out_valid !== 1'b0 || Sum !== 8'h00 || Cout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: got ov=%b sum=%h cout=%b, want ov=0 sum=00 cout=0", out_valid, Sum, Cout);
    end
    vectors++;
    if (cfg_loaded !== 1'b0 || cfg_ready !== 1'b0 || cfg_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cfg: got loaded=%b ready=%b done=%b, want 0 0 0", cfg_loaded, cfg_ready, cfg_done);
    end
    in_valid = 1'b0;
    $display("test_reset: unconfigured 12+34 ignored");
  endtask

  task automatic test_adder();
    done_cnt = 0;
    start_load();
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_ready: got %b, want 1", cfg_ready);
    end
    beats(8'h96, 8'hE8, 0, NB - 1);
    vectors++;
    if (cfg_done !== 1'b1 || cfg_loaded !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_pulse: got done=%b loaded=%b, want 1 1", cfg_done, cfg_loaded);
    end
    step(); step();
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL done_count: got %0d, want 1", done_cnt);
    end
    apply(8'hAA, 8'h55, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || Sum !== 8'hFF || Cout !== 1'b0) begin
      miscompares++;
      $display("FAIL add_aa_55: got ov=%b sum=%h cout=%b, want 1 ff 0", out_valid, Sum, Cout);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || Sum !== 8'hFF) begin
      miscompares++;
      $display("FAIL hold: got ov=%b sum=%h, want 0 ff", out_valid, Sum);
    end
    $display("test_adder: AA+55 -> %h cout %b", Sum, Cout);
  endtask

  task automatic test_adder_edges();
    apply(8'hFF, 8'h01, 1'b0);
    vectors++;
    if (Sum !== 8'h00 || Cout !== 1'b1) begin
      miscompares++;
      $display("FAIL add_ff_01: got sum=%h cout=%b, want 00 1", Sum, Cout);
    end
    apply(8'h00, 8'h00, 1'b1);
    vectors++;
    if (Sum !== 8'h01 || Cout !== 1'b0) begin
      miscompares++;
      $display("FAIL add_cin: got sum=%h cout=%b, want 01 0", Sum, Cout);
    end
    $display("test_adder_edges: 00+00+1 -> %h cout %b", Sum, Cout);
  endtask

  task automatic test_reload();
    start_load();
    beats(8'h66, 8'h00, 0, MID - 1);
    apply(8'hFF, 8'h01, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || Sum !== 8'h00 || Cout !== 1'b1) begin
      miscompares++;
      $display("FAIL old_cfg_in_load: got ov=%b sum=%h cout=%b, want 1 00 1", out_valid, Sum, Cout);
    end
    beats(8'h66, 8'h00, MID, NB - 2);
    cfg_valid = 1'b1; cfg_data = 8'h00;
    in_valid = 1'b1; In_1 = 8'hFF; In_2 = 8'h01; cin = 1'b0;
    step();
    cfg_valid = 1'b0; in_valid = 1'b0;
    vectors++;
    if (cfg_done !== 1'b1 || Sum !== 8'h00 || Cout !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_edge_op: got done=%b sum=%h cout=%b, want 1 00 1", cfg_done, Sum, Cout);
    end
    apply(8'hF0, 8'h3C, 1'b0);
    vectors++;
    if (Sum !== 8'hCC || Cout !== 1'b0) begin
      miscompares++;
      $display("FAIL xor_f0_3c: got sum=%h cout=%b, want cc 0", Sum, Cout);
    end
    $display("test_reload: XOR F0^3C -> %h", Sum);
  endtask

  task automatic test_abort();
    done_cnt = 0;
    start_load();
    beats(8'h96, 8'hE8, 0, MID - 1);
    start_load();
    beats(8'h96, 8'hE8, 0, NB - 2);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hE8;
    step();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    step(); step();
    vectors++;
    if (done_cnt !== 0 || cfg_loaded !== 1'b1 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort: got dones=%0d loaded=%b ready=%b, want 0 1 1", done_cnt, cfg_loaded, cfg_ready);
    end
    apply(8'hF0, 8'h3C, 1'b0);
    vectors++;
    if (Sum !== 8'hCC || Cout !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_keeps_xor: got sum=%h cout=%b, want cc 0", Sum, Cout);
    end
    beats(8'h96, 8'hE8, 0, NB - 1);
    step();
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL reload_after_abort: got %0d dones, want 1", done_cnt);
    end
    apply(8'hAA, 8'h55, 1'b0);
    vectors++;
    if (Sum !== 8'hFF || Cout !== 1'b0) begin
      miscompares++;
      $display("FAIL adder_after_abort: got sum=%h cout=%b, want ff 0", Sum, Cout);
    end
    $display("test_abort: dropped final beat, reload AA+55 -> %h", Sum);
  endtask

  task automatic test_reset_midload();
    start_load();
    beats(8'h66, 8'h00, 0, RB - 1);
    reset = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || Sum !== 8'h00 || Cout !== 1'b0 || cfg_loaded !== 1'b0 || cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_reset: got ov=%b sum=%h cout=%b loaded=%b ready=%b, want all 0",
               out_valid, Sum, Cout, cfg_loaded, cfg_ready);
    end
    reset = 1'b1;
    apply(8'h12, 8'h34, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_op: got ov=%b, want 0", out_valid);
    end
    done_cnt = 0;
    start_load();
    beats(8'h96, 8'hE8, 0, NB - 1);
    step();
    apply(8'hAA, 8'h55, 1'b0);
    vectors++;
    if (done_cnt !== 1 || Sum !== 8'hFF || Cout !== 1'b0) begin
      miscompares++;
      $display("FAIL fresh_load: got dones=%0d sum=%h cout=%b, want 1 ff 0", done_cnt, Sum, Cout);
    end
    $display("test_reset_midload: fresh load AA+55 -> %h", Sum);
  endtask

  initial begin
    reset = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    in_valid = 1'b0; In_1 = 8'h00; In_2 = 8'h00; cin = 1'b0;
    step(); step();
    test_reset();
    test_adder();
    test_adder_edges();
    test_reload();
    test_abort();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
